crossbar_return_demux: RTL and testbench
========================================

Name: crossbar_return_demux

Overview:
- Return-path stage of the crossbar. Takes one response stream from a master port. Each beat carries the originating slave id stamped by the forward arbiter.
- Steers every packet back to that slave's output lane, packet-locked.
- Registered 2-entry output (main + skid), so m_ready_o never depends combinationally on s_ready_i.
- Flags id protocol violations.

Parameters:
T_DATA_WIDTH, 8, data beat width
S_DATA_COUNT, 3, number of slave lanes to route back to
T_ID___WIDTH, $clog2(S_DATA_COUNT), width of id field

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
m_data_i  input  T_DATA_WIDTH  response beat data
m_id_i  input  T_ID___WIDTH  destination slave id
m_last_i  input  1  last beat of packet
m_valid_i  input  1  beat valid
m_ready_o  output  1  beat accepted when m_valid_i && m_ready_o
s_data_o  output  T_DATA_WIDTH x [S_DATA_COUNT]  per-lane data (all lanes carry the same OUT data)
s_last_o  output  S_DATA_COUNT  per-lane last
s_valid_o  output  S_DATA_COUNT  per-lane valid, at most one bit set
s_ready_i  input  S_DATA_COUNT  per-lane ready
busy_o  output  1  high while a packet is open (state != IDLE)
err_o  output  1  sticky protocol-error flag

Behaviour:
- Storage
  - OUT register: data, last, id, valid.
  - SKID register: data, last, id, valid.
- Ready and handshakes
  - m_ready_o = ~skid_valid, driven directly from the register.
  - Input accept: acc = m_valid_i && m_ready_o.
  - s_valid_o[out_id] = out_valid; all other bits are 0. s_last_o is masked the same way.
  - Output fire: fire = out_valid && s_ready_i[out_id]. Ready on other lanes is ignored.
- Register update, each cycle
  - fire && skid_valid: OUT <= SKID, skid_valid <= 0. An accept in the same cycle is impossible because m_ready_o = 0.
  - acc && (!out_valid || fire): OUT <= beat.
  - acc && out_valid && !fire: SKID <= beat.
  - fire, no refill: out_valid <= 0.
- Latency and throughput
  - Accepted beat appears on s_valid_o the next cycle.
  - Sustained 1 beat/cycle when the target lane is always ready.
  - Beat order is preserved.
- FSM (states IDLE, PKT, DROP); routing is decided at accept time.
  - IDLE, acc, m_id_i < S_DATA_COUNT: route to m_id_i and latch lock_id <= m_id_i. Go to PKT if !m_last_i, else stay in IDLE.
  - IDLE, acc, m_id_i >= S_DATA_COUNT: beat is accepted but not stored, err_o <= 1. Go to DROP if !m_last_i, else stay in IDLE.
  - PKT, acc: route to lock_id regardless of m_id_i. If m_id_i != lock_id, err_o <= 1 and the beat is still delivered to lock_id. m_last_i -> IDLE.
  - DROP, acc: discard the beat. m_last_i -> IDLE.
  - Dropped beats never occupy OUT/SKID and never block the input, provided m_ready_o = 1.
- Wrap and edge cases
  - Lane ready toggling mid-packet stalls only via backpressure; no beat is lost or duplicated.
  - Simultaneous fire and accept with SKID empty: OUT is refilled the same edge. No bubble.
  - Packet of length 1 (first beat has last = 1): FSM stays in IDLE.
  - Next packet may target a different lane while the previous packet's last beat still sits in OUT/SKID. Each beat keeps the id stored with it.
- Reset
  - Asynchronous, rst_n low, including mid-packet: out_valid = skid_valid = 0, FSM = IDLE, err_o = 0, lock_id = 0.
  - Resulting outputs: s_valid_o = 0, s_last_o = 0, busy_o = 0, m_ready_o = 1.
  - OUT/SKID data contents are don't-care.
  - Any in-flight beats are discarded.
- err_o clears only on reset.

Test Plan:
1. Reset, then 3-beat packet id=2 (0xA1, 0xA2, 0xA3 last) with s_ready_i=3'b111 -> s_valid_o=3'b100 for 3 consecutive cycles starting 1 cycle after the first accept; data 0xA1/0xA2/0xA3, s_last_o[2] on the third beat only; busy_o high across the packet; err_o=0.
2. Backpressure: packet to id=1, 4 beats, s_ready_i[1] held 0 for 5 cycles -> m_ready_o drops after 2 beats are accepted (OUT+SKID full); after release, beats emerge in order with none lost or duplicated.
3. Id changes mid-packet: first beat id=0, second beat id=1, third beat id=0 with last -> all three delivered on lane 0; err_o rises the cycle after the second accept and stays 1.
4. Out-of-range id=3: 2-beat packet -> m_ready_o stays 1, s_valid_o stays 0, err_o=1. A following packet id=1 (0x55, last) is delivered on lane 1.
5. Back-to-back packets id=0 (1 beat, last) then id=2 (2 beats), lanes always ready -> no idle cycle between s_valid_o[0] and s_valid_o[2].
6. Assert rst_n low while in PKT with OUT and SKID full -> s_valid_o=0, busy_o=0, m_ready_o=1, err_o=0 immediately. After release, a new packet id=1 routes normally.

Source files
------------

// File: rtl/crossbar_return_demux.sv
// Return-path demux: steers packets from one master stream back to the
// originating slave lane, with a registered main+skid output stage.
module crossbar_return_demux #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [T_DATA_WIDTH-1:0]                  m_data_i,
  input  logic [T_ID___WIDTH-1:0]                  m_id_i,
  input  logic                                     m_last_i,
  input  logic                                     m_valid_i,
  output logic                                     m_ready_o,
  output logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_o,
  output logic [S_DATA_COUNT-1:0]                  s_last_o,
  output logic [S_DATA_COUNT-1:0]                  s_valid_o,
  input  logic [S_DATA_COUNT-1:0]                  s_ready_i,
  output logic                                     busy_o,
  output logic                                     err_o
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  localparam logic [T_ID___WIDTH:0] ID_LIM =
    (T_ID___WIDTH+1)'(S_DATA_COUNT);

  state_t                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_id, lock_d, dest_id;
  logic                    err_q, err_set;

  logic [T_DATA_WIDTH-1:0] out_data, skid_data;
  logic [T_ID___WIDTH-1:0] out_id, skid_id;
  logic                    out_last, skid_last;
  logic                    out_valid, skid_valid;

  logic acc, fire, store, in_range;

  assign m_ready_o = ~skid_valid;
  assign acc       = m_valid_i && m_ready_o;
  assign in_range  = {1'b0, m_id_i} < ID_LIM;
  assign busy_o    = state_q != IDLE;
  assign err_o     = err_q;

  always_comb begin
    fire = 1'b0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      s_valid_o[i] = out_valid && (out_id == T_ID___WIDTH'(i));
      s_last_o[i]  = s_valid_o[i] && out_last;
      s_data_o[i]  = out_data;
      if (s_valid_o[i] && s_ready_i[i]) fire = 1'b1;
    end
  end

  // Routing is decided when a beat is accepted, never when it leaves.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_id;
    dest_id = lock_id;
    store   = 1'b0;
    err_set = 1'b0;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (in_range) begin
            store   = 1'b1;
            dest_id = m_id_i;
            lock_d  = m_id_i;
            if (!m_last_i) state_d = PKT;
          end else begin
            err_set = 1'b1;
            if (!m_last_i) state_d = DROP;
          end
        end
        PKT: begin
          store   = 1'b1;
          err_set = m_id_i != lock_id;
          if (m_last_i) state_d = IDLE;
        end
        DROP: begin
          if (m_last_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_id <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_id <= lock_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      out_last   <= 1'b0;
      skid_data  <= '0;
      skid_id    <= '0;
      skid_last  <= 1'b0;
    end else if (fire && skid_valid) begin
      out_data   <= skid_data;
      out_id     <= skid_id;
      out_last   <= skid_last;
      skid_valid <= 1'b0;
    end else if (store && (!out_valid || fire)) begin
      out_data   <= m_data_i;
      out_id     <= dest_id;
      out_last   <= m_last_i;
      out_valid  <= 1'b1;
    end else if (store) begin
      skid_data  <= m_data_i;
      skid_id    <= dest_id;
      skid_last  <= m_last_i;
      skid_valid <= 1'b1;
    end else if (fire) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crossbar_return_demux.sv
// Scoreboard bench for crossbar_return_demux: directed scenarios plus
// randomized packets checked against a packet-level reference model.
module tb_crossbar_return_demux;

  localparam int DW = 8;
  localparam int NS = 3;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DW-1:0]      m_data_i = '0;
  logic [IW-1:0]      m_id_i = '0;
  logic               m_last_i = 1'b0;
  logic               m_valid_i = 1'b0;
  logic               m_ready_o;
  logic [NS-1:0][DW-1:0] s_data_o;
  logic [NS-1:0]      s_last_o;
  logic [NS-1:0]      s_valid_o;
  logic [NS-1:0]      s_ready_i = '1;
  logic               busy_o;
  logic               err_o;

  crossbar_return_demux #(
    .T_DATA_WIDTH(DW),
    .S_DATA_COUNT(NS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_data_i(m_data_i),
    .m_id_i(m_id_i),
    .m_last_i(m_last_i),
    .m_valid_i(m_valid_i),
    .m_ready_o(m_ready_o),
    .s_data_o(s_data_o),
    .s_last_o(s_last_o),
    .s_valid_o(s_valid_o),
    .s_ready_i(s_ready_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        lane;
    logic [7:0] data;
    bit        last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   accepted = 0;
  bit   rnd_ready = 1'b0;

  // Reference model: packet-level view of where each beat must go.
  int   mdl_mode = 0;  // 0 between packets, 1 delivering, 2 discarding
  int   mdl_lock = 0;
  bit   mdl_err  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_accept(input int id, input logic [7:0] d, input bit last);
    case (mdl_mode)
      0: begin
        if (id < NS) begin
          exp_q.push_back('{id, d, last});
          mdl_lock = id;
          if (!last) mdl_mode = 1;
        end else begin
          mdl_err = 1'b1;
          if (!last) mdl_mode = 2;
        end
      end
      1: begin
        exp_q.push_back('{mdl_lock, d, last});
        if (id != mdl_lock) mdl_err = 1'b1;
        if (last) mdl_mode = 0;
      end
      default: if (last) mdl_mode = 0;
    endcase
  endtask

  task automatic send(input int id, input logic [7:0] d, input bit last);
    int n = 0;
    m_valid_i = 1'b1;
    m_id_i    = IW'(id);
    m_data_i  = d;
    m_last_i  = last;
    while (1) begin
      @(negedge clk);
      if (m_ready_o) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        m_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    accepted++;
    model_accept(id, d, last);
  endtask

  task automatic stop_in();
    m_valid_i = 1'b0;
    m_last_i  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_ready = 1'b0;
    s_ready_i = '1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) s_ready_i = NS'($urandom);
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("valid_onehot", int'($onehot0(s_valid_o)), 1);
      for (int i = 0; i < NS; i++) begin
        if (s_valid_o[i] && s_ready_i[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_lane", i, -1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_lane", i, e.lane);
            chk("beat_data", int'(s_data_o[i]), int'(e.data));
            chk("beat_last", int'(s_last_o[i]), int'(e.last));
          end
        end
      end
      chk("err_flag", int'(err_o), int'(mdl_err));
      chk("busy", int'(busy_o), int'(mdl_mode != 0));
    end
  end

  initial begin
    s_ready_i = 3'b111;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(s_valid_o), 0);
    chk("rst_last", int'(s_last_o), 0);
    chk("rst_ready", int'(m_ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_err", int'(err_o), 0);
    @(posedge clk);
    #1;

    // Basic 3-beat packet on lane 2
    send(2, 8'hA1, 0);
    chk("t1_lane2_after_accept", int'(s_valid_o), 3'b100);
    send(2, 8'hA2, 0);
    send(2, 8'hA3, 1);
    stop_in();
    drain();

    // Backpressure on lane 1
    s_ready_i = 3'b101;
    accepted = 0;
    fork
      begin
        send(1, 8'hB0, 0);
        send(1, 8'hB1, 0);
        send(1, 8'hB2, 0);
        send(1, 8'hB3, 1);
        stop_in();
      end
      begin
        int n = 0;
        while (accepted < 2 && n < 50) begin
          @(posedge clk);
          n++;
        end
        @(negedge clk);
        chk("t2_ready_low_full", int'(m_ready_o), 0);
        chk("t2_accepted", accepted, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_still_stalled", accepted, 2);
        s_ready_i = 3'b111;
      end
    join
    drain();

    // Id changes mid-packet
    send(0, 8'hC0, 0);
    send(1, 8'hC1, 0);
    send(0, 8'hC2, 1);
    stop_in();
    drain();
    chk("t3_err_sticky", int'(err_o), 1);

    // Out-of-range id dropped, then a normal packet
    send(3, 8'hD0, 0);
    chk("t4_ready_kept", int'(m_ready_o), 1);
    send(3, 8'hD1, 1);
    send(1, 8'h55, 1);
    stop_in();
    drain();

    // Back-to-back packets, no bubble between lanes
    fork
      begin
        send(0, 8'h10, 1);
        send(2, 8'h20, 0);
        send(2, 8'h21, 1);
        stop_in();
      end
      begin
        int n = 0;
        while (!s_valid_o[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        chk("t5_no_bubble_1", int'(s_valid_o), 3'b100);
        @(negedge clk);
        chk("t5_no_bubble_2", int'(s_valid_o), 3'b100);
      end
    join
    drain();

    // Reset mid-packet with OUT and SKID full
    s_ready_i = 3'b000;
    send(1, 8'hE0, 0);
    send(1, 8'hE1, 0);
    stop_in();
    @(negedge clk);
    chk("t6_full_ready", int'(m_ready_o), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(s_valid_o), 0);
    chk("t6_rst_busy", int'(busy_o), 0);
    chk("t6_rst_ready", int'(m_ready_o), 1);
    chk("t6_rst_err", int'(err_o), 0);
    exp_q.delete();
    mdl_mode = 0;
    mdl_lock = 0;
    mdl_err  = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    s_ready_i = 3'b111;
    @(posedge clk);
    #1;
    send(1, 8'hF0, 0);
    send(1, 8'hF1, 1);
    stop_in();
    drain();

    // Randomized packets with random lane readiness
    rnd_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int id  = $urandom_range(0, 3);
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        int bid = id;
        if (b > 0 && $urandom_range(0, 7) == 0) bid = $urandom_range(0, 3);
        send(bid, 8'($urandom), b == len - 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        stop_in();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    stop_in();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
